// File: rtl/bound_flasher_gen.sv
// Thermometer LED bar sweeping through six on/off phases between two bounds, with flick kickback.
// Latency: level/phase/led/busy all update on the same step edge; no added pipeline delay.
// No backpressure: flick and repeat_mode are sampled only on prescaler step cycles, otherwise ignored.
module bound_flasher_gen #(
  parameter int N_LED    = 16,
  parameter int B1       = 5,
  parameter int B2       = 10,
  parameter int STEP_DIV = 1,
  localparam int LW      = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
  input  logic             repeat_mode,
  output logic [N_LED-1:0] led,
  output logic [LW-1:0]    level,
  output logic [2:0]       phase,
  output logic             busy
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  localparam logic [LW-1:0] LV_B1   = LW'(B1);
  localparam logic [LW-1:0] LV_B1P1 = LW'(B1 + 1);
  localparam logic [LW-1:0] LV_B2   = LW'(B2);
  localparam logic [LW-1:0] LV_B2P1 = LW'(B2 + 1);
  localparam logic [LW-1:0] LV_TOP  = LW'(N_LED);

  // Reject illegal geometry at elaboration rather than build a bar that cannot sweep.
  if (N_LED < 4 || N_LED > 64) begin : g_chk_nled
    $error("bound_flasher_gen: N_LED must be in 4..64");
  end
  if (B1 < 0 || B1 >= B2) begin : g_chk_b1
    $error("bound_flasher_gen: need 0 <= B1 < B2");
  end
  if (B2 >= N_LED - 1) begin : g_chk_b2
    $error("bound_flasher_gen: need B2 < N_LED-1");
  end
  if (STEP_DIV < 1) begin : g_chk_div
    $error("bound_flasher_gen: STEP_DIV must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ON_B1   = 3'd1,
    OFF_0   = 3'd2,
    ON_B2   = 3'd3,
    OFF_B1  = 3'd4,
    ON_TOP  = 3'd5,
    OFF_END = 3'd6
  } phase_t;

  phase_t            phase_q, phase_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     lvl_up, lvl_dn;
  logic [N_LED-1:0]  led_q, led_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              step;

  // Free-running prescaler; the step strobe fires on its last count.
  always_comb begin
    step    = (presc_q == PRESC_LAST);
    presc_d = step ? '0 : presc_q + PW'(1);
  end

  // Next phase/level: saturating +/-1 per step, phase turns exactly at the bounds.
  always_comb begin
    phase_d = phase_q;
    level_d = level_q;
    lvl_up  = (level_q < LV_TOP) ? level_q + LW'(1) : level_q;
    lvl_dn  = (level_q != '0)    ? level_q - LW'(1) : level_q;
    if (step) begin
      case (phase_q)
        IDLE: begin
          level_d = '0;
          if (flick) phase_d = ON_B1;
        end
        ON_B1: begin
          level_d = lvl_up;
          if (lvl_up == LV_B1P1) phase_d = OFF_0;
        end
        OFF_0: begin
          level_d = lvl_dn;
          if (lvl_dn == '0) phase_d = ON_B2;
        end
        ON_B2: begin
          level_d = lvl_up;
          if (lvl_up == LV_B2P1) phase_d = OFF_B1;
        end
        OFF_B1: begin
          level_d = lvl_dn;
          if (lvl_dn == LV_B1) phase_d = flick ? ON_B2 : ON_TOP;
        end
        ON_TOP: begin
          level_d = lvl_up;
          if (lvl_up == LV_TOP) phase_d = OFF_END;
        end
        OFF_END: begin
          level_d = lvl_dn;
          if (lvl_dn == '0) begin
            phase_d = repeat_mode ? ON_B1 : IDLE;
          end else if (flick && (lvl_dn == LV_B2 || lvl_dn == LV_B1)) begin
            phase_d = ON_TOP;
          end
        end
        default: begin
          phase_d = IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  // LED bar and busy flag are derived from the next state so they register alongside it.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LED; i++) begin
      led_d[i] = (level_d > LW'(i));
    end
    busy_d = (phase_d != IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= IDLE;
      level_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      presc_q <= presc_d;
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign phase = phase_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bound_flasher_gen.sv
module tb_bound_flasher_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fl [3];
  logic rp [3];

  always #5 clk = ~clk;

  logic [15:0] led_a, led_b;
  logic [7:0]  led_c;
  logic [4:0]  lvl_a, lvl_b;
  logic [3:0]  lvl_c;
  logic [2:0]  ph_a, ph_b, ph_c;
  logic        busy_a, busy_b, busy_c;

  bound_flasher_gen u_a (
    .clk(clk), .rst_n(rst_n), .flick(fl[0]), .repeat_mode(rp[0]),
    .led(led_a), .level(lvl_a), .phase(ph_a), .busy(busy_a)
  );
  bound_flasher_gen #(.STEP_DIV(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flick(fl[1]), .repeat_mode(rp[1]),
    .led(led_b), .level(lvl_b), .phase(ph_b), .busy(busy_b)
  );
  bound_flasher_gen #(.N_LED(8), .B1(1), .B2(4)) u_c (
    .clk(clk), .rst_n(rst_n), .flick(fl[2]), .repeat_mode(rp[2]),
    .led(led_c), .level(lvl_c), .phase(ph_c), .busy(busy_c)
  );

  int total = 0;
  int bad = 0;

  // Reference model: sweep = list of six segments (up/down to a target level).
  int mN   [3] = '{16, 16, 8};
  int mB1  [3] = '{5, 5, 1};
  int mB2  [3] = '{10, 10, 4};
  int mdiv [3] = '{1, 4, 1};
  int mseg [3];
  int mlvl [3];
  int mpre [3];
  int tp [$];

  function automatic int seg_target(input int i, input int s);
    case (s)
      0: return mB1[i] + 1;
      1: return 0;
      2: return mB2[i] + 1;
      3: return mB1[i];
      4: return mN[i];
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mseg[i] = -1;
      mlvl[i] = 0;
      mpre[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic f, input logic r);
    if (mpre[i] != mdiv[i] - 1) begin
      mpre[i]++;
      return;
    end
    mpre[i] = 0;
    if (mseg[i] < 0) begin
      if (f) mseg[i] = 0;
      return;
    end
    mlvl[i] += (mseg[i] % 2 == 0) ? 1 : -1;
    if (mlvl[i] == seg_target(i, mseg[i])) begin
      if (mseg[i] == 3)      mseg[i] = f ? 2 : 4;
      else if (mseg[i] == 5) mseg[i] = r ? 0 : -1;
      else                   mseg[i]++;
    end else if (mseg[i] == 5 && f && (mlvl[i] == mB1[i] || mlvl[i] == mB2[i])) begin
      mseg[i] = 4;
    end
  endtask

  function automatic logic [63:0] model_pack(input int i);
    logic [63:0] th;
    th = (64'd1 << mlvl[i]) - 64'd1;
    return (th << 16) | (64'(mlvl[i]) << 8) | (64'(mseg[i] + 1) << 4) | 64'(mseg[i] >= 0);
  endfunction

  function automatic logic [63:0] dut_pack(input int i);
    case (i)
      0: return (64'(led_a) << 16) | (64'(lvl_a) << 8) | (64'(ph_a) << 4) | 64'(busy_a);
      1: return (64'(led_b) << 16) | (64'(lvl_b) << 8) | (64'(ph_b) << 4) | 64'(busy_b);
      default: return (64'(led_c) << 16) | (64'(lvl_c) << 8) | (64'(ph_c) << 4) | 64'(busy_c);
    endcase
  endfunction

  function automatic int get_ph(input int i);
    case (i)
      0: return int'(ph_a);
      1: return int'(ph_b);
      default: return int'(ph_c);
    endcase
  endfunction

  function automatic int get_lvl(input int i);
    case (i)
      0: return int'(lvl_a);
      1: return int'(lvl_b);
      default: return int'(lvl_c);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) model_step(i, fl[i], rp[i]);
    end
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("model_u%0d", i), dut_pack(i), model_pack(i));
  endtask

  task automatic wait_for(input int i, input int ph, input int lv, input int maxc, input string tag);
    int c;
    c = 0;
    while (!(get_ph(i) == ph && get_lvl(i) == lv) && c < maxc) begin
      tick();
      c++;
    end
    check(tag, 64'(get_ph(i) == ph && get_lvl(i) == lv), 64'd1);
  endtask

  task automatic check_tp(input string tag, input int ex [6]);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("%s_%0d", tag, k), 64'(tp.size() > k ? tp[k] : -1), 64'(ex[k]));
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks it lands before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("%s_u%0d", tag, i), dut_pack(i), 64'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, pp, cur, last, prev, low_seen;
    int ex_def [6] = '{6, 0, 11, 5, 16, 0};
    int ex_c   [6] = '{2, 0, 5, 1, 8, 0};
    for (int i = 0; i < 3; i++) begin
      fl[i] = 1'b0;
      rp[i] = 1'b0;
    end
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    for (int i = 0; i < 3; i++) check($sformatf("rst_state_u%0d", i), dut_pack(i), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full default sweep with one-cycle flick
    fl[0] = 1'b1;
    tick();
    check("start_phase", 64'(ph_a), 64'd1);
    check("start_level", 64'(lvl_a), 64'd0);
    fl[0] = 1'b0;
    tick();
    check("first_led", 64'(led_a), 64'h0001);
    n = 2;
    pp = 1;
    tp.delete();
    while (ph_a != 3'd0 && n < 200) begin
      tick();
      n++;
      cur = int'(ph_a);
      if (cur != pp && pp != 0) tp.push_back(int'(lvl_a));
      pp = cur;
    end
    check("sweep_len", 64'(n), 64'd57);
    check_tp("peak_def", ex_def);

    // Kickback at B1 and in OFF_END
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    wait_for(0, 4, 6, 100, "reach_offb1_6");
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    check("kick_b1", {59'd0, ph_a, 1'b0} | (64'(lvl_a) << 8), (64'd5 << 8) | 64'd6);
    wait_for(0, 6, 11, 100, "reach_offend_11");
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    check("kick_top_ph", 64'(ph_a), 64'd5);
    check("kick_top_lvl", 64'(lvl_a), 64'd10);
    wait_for(0, 6, 13, 100, "reach_offend_13");
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    check("nokick_ph", 64'(ph_a), 64'd6);
    check("nokick_lvl", 64'(lvl_a), 64'd12);
    wait_for(0, 0, 0, 100, "kick_done");

    // Prescaler: short flick between steps is missed
    while (mpre[1] == 3) tick();
    fl[1] = 1'b1;
    while (mpre[1] != 3) tick();
    fl[1] = 1'b0;
    tick();
    check("presc_miss", 64'(ph_b), 64'd0);
    fl[1] = 1'b1;
    n = 0;
    while (ph_b == 3'd0 && n < 8) begin
      tick();
      n++;
    end
    fl[1] = 1'b0;
    check("presc_start", 64'(ph_b), 64'd1);
    last = -1;
    prev = int'(lvl_b);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (int'(lvl_b) != prev) begin
        if (last >= 0) check("presc_gap", 64'(c - last), 64'd4);
        last = c;
        prev = int'(lvl_b);
      end
    end
    wait_for(1, 0, 0, 400, "presc_done");

    // Repeat mode on the small bar
    rp[2] = 1'b1;
    fl[2] = 1'b1;
    tick();
    fl[2] = 1'b0;
    tp.delete();
    pp = 1;
    n = 0;
    low_seen = 0;
    while (tp.size() < 6 && n < 200) begin
      tick();
      n++;
      if (!busy_c) low_seen++;
      cur = int'(ph_c);
      if (cur != pp && pp != 0) tp.push_back(int'(lvl_c));
      pp = cur;
    end
    check("rep_phase", 64'(ph_c), 64'd1);
    check("rep_busy", 64'(low_seen), 64'd0);
    check_tp("peak_c", ex_c);
    rp[2] = 1'b0;
    wait_for(2, 0, 0, 200, "rep_done");

    // Reset mid-sweep at level 7 in ON_B2
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    wait_for(0, 3, 7, 100, "reach_onb2_7");
    async_reset("rst_mid");
    repeat (5) tick();
    check("rst_stay_idle", 64'(ph_a), 64'd0);

    // Randomised traffic against the model, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        fl[i] = ($urandom_range(0, 7) == 0);
        rp[i] = ($urandom_range(0, 3) != 0);
      end
      if (c == 1500) async_reset("rst_rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
